bp_fe_ras: RTL and testbench
============================

Name: bp_fe_ras

Overview:
- Parametrised return-address stack for the front-end branch predictor. Replaces the fixed 16-bit, fixed-depth stack.
- Pushes call return addresses and pops them on returns, as a circular buffer that overwrites the oldest entry on overflow.
- Exports a checkpoint (pointer + occupancy) so the front end can restore stack state after a misprediction redirect.

Parameters:
- width_p, 39, return-address width in bits
- els_p, 8, stack depth; power of two, >= 2
- ptr_width_lp, $clog2(els_p), top-of-stack pointer width (derived, not overridden)
- count_width_lp, $clog2(els_p+1), occupancy counter width (derived)

Ports:
- clk_i  input  1  clock
- reset_i  input  1  synchronous active-high reset
- push_i  input  1  push w_data_i (call)
- w_data_i  input  width_p  return address to push
- pop_i  input  1  pop top entry (return)
- r_data_o  output  width_p  current top-of-stack value
- r_v_o  output  1  r_data_o valid (stack non-empty)
- full_o  output  1  count == els_p
- count_o  output  count_width_lp  current occupancy
- ckpt_ptr_o  output  ptr_width_lp  current top-of-stack pointer, for checkpointing
- restore_i  input  1  load pointer and count from restore inputs
- restore_ptr_i  input  ptr_width_lp  pointer to restore
- restore_count_i  input  count_width_lp  occupancy to restore

Behaviour:
- Clocking and reset: one clock, clk_i; reset_i is synchronous, active-high.
- State: mem[els_p] x width_p; tos_ptr indexes the next free slot; count in 0..els_p.
- Memory is not reset.
- Reset: tos_ptr=0, count=0. Hence r_v_o=0, r_data_o=0, full_o=0, count_o=0, ckpt_ptr_o=0.
- Read path is combinational from state:
  - r_data_o = mem[tos_ptr-1 mod els_p] when count!=0, else 0.
  - r_v_o = (count!=0).
- Latency: all state updates take effect at the next clock edge; a pushed value appears on r_data_o the cycle after the push.
- Priority: reset_i > restore_i > push/pop.
- restore_i=1:
  - tos_ptr <= restore_ptr_i; count <= min(restore_count_i, els_p).
  - mem untouched; push_i/pop_i ignored that cycle.
- Push only:
  - mem[tos_ptr] <= w_data_i; tos_ptr <= tos_ptr+1 (wraps mod els_p).
  - count <= count+1, saturating at els_p.
  - Push when full overwrites the oldest entry (overflow); count stays els_p.
- Pop only:
  - If count!=0: tos_ptr <= tos_ptr-1 (wraps); count <= count-1.
  - If count==0 (underflow): no state change.
- Push and pop together (return followed by call):
  - If count!=0: replace top, i.e. mem[tos_ptr-1] <= w_data_i; tos_ptr and count unchanged.
  - If count==0: behaves exactly as push only.
- Overflow followed by els_p+1 pops: the first els_p pops return the newest els_p values; the final pop is an underflow (r_v_o=0).
- All pointer arithmetic is modulo els_p with no out-of-range index; count arithmetic never wraps.

Optional Feature:
- Macro: BP_FE_RAS_STATS_EN.
- Defined: adds outputs overflow_cnt_o[15:0] and underflow_cnt_o[15:0].
  - Both reset to 0 and saturate at 16'hFFFF.
  - overflow_cnt_o increments on each push-only cycle with full_o=1.
  - underflow_cnt_o increments on each pop-only cycle with count==0.
  - Neither counter increments in a cycle where restore_i=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> count_o=3, r_data_o=0x300; three pops -> r_data_o 0x200, 0x100, then r_v_o=0 with r_data_o=0.
- els_p=8: push 0x1..0x9 -> full_o=1, count_o=8, r_data_o=0x9; 9 pops -> returns 0x9..0x2, then underflow (r_v_o=0); with STATS_EN, overflow_cnt_o=1 and underflow_cnt_o=1.
- Push 0xA, 0xB, then push+pop with 0xC -> count_o=2, r_data_o=0xC; pop -> r_data_o=0xA. On an empty stack, push+pop with 0xD -> count_o=1, r_data_o=0xD.
- Push 0x10, 0x20; capture ckpt_ptr_o=2, count_o=2; push 0x30, pop, pop, pop; then restore_i with ptr=2, count=2 alongside pop_i=1 -> pop ignored, r_data_o=0x20, count_o=2.
- restore_count_i=15 with els_p=8 -> count_o=8, full_o=1.
- reset_i asserted mid-sequence together with push_i -> next cycle count_o=0, r_v_o=0, ckpt_ptr_o=0; a following push 0x55 -> r_data_o=0x55.

Source files
------------

// File: rtl/bp_fe_ras.sv
// Parametrised return-address stack: circular buffer overwriting the oldest entry on overflow,
// with checkpoint/restore of pointer and occupancy. Define BP_FE_RAS_STATS_EN for overflow/underflow counters.
module bp_fe_ras #(
  parameter  int width_p        = 39,
  parameter  int els_p          = 8,
  localparam int ptr_width_lp   = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      push_i,
  input  logic [width_p-1:0]        w_data_i,
  input  logic                      pop_i,
  output logic [width_p-1:0]        r_data_o,
  output logic                      r_v_o,
  output logic                      full_o,
  output logic [count_width_lp-1:0] count_o,
  output logic [ptr_width_lp-1:0]   ckpt_ptr_o,
  input  logic                      restore_i,
  input  logic [ptr_width_lp-1:0]   restore_ptr_i,
`ifdef BP_FE_RAS_STATS_EN
  input  logic [count_width_lp-1:0] restore_count_i,
  output logic [15:0]               overflow_cnt_o,
  output logic [15:0]               underflow_cnt_o
`else
  input  logic [count_width_lp-1:0] restore_count_i
`endif
);

  localparam logic [count_width_lp-1:0] els_cnt_lp = count_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0]   ptr_one_lp = ptr_width_lp'(1);
  localparam logic [count_width_lp-1:0] cnt_one_lp = count_width_lp'(1);

  logic [width_p-1:0]        mem [els_p];
  logic [ptr_width_lp-1:0]   tos_ptr, tos_ptr_n, top_idx;
  logic [count_width_lp-1:0] count, count_n;
  logic                      empty, full;
  logic                      mem_we;
  logic [ptr_width_lp-1:0]   mem_waddr;

  function automatic logic [count_width_lp-1:0] clamp_count(input logic [count_width_lp-1:0] c);
    return (c > els_cnt_lp) ? els_cnt_lp : c;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == els_cnt_lp);
  // Pointer width is exactly log2(els_p), so natural wrap gives the modulo.
  assign top_idx = tos_ptr - ptr_one_lp;

  assign r_v_o      = ~empty;
  assign r_data_o   = empty ? '0 : mem[top_idx];
  assign full_o     = full;
  assign count_o    = count;
  assign ckpt_ptr_o = tos_ptr;

  always_comb begin
    tos_ptr_n = tos_ptr;
    count_n   = count;
    mem_we    = 1'b0;
    mem_waddr = tos_ptr;
    if (restore_i) begin
      tos_ptr_n = restore_ptr_i;
      count_n   = clamp_count(restore_count_i);
    end else if (push_i && (!pop_i || empty)) begin
      mem_we    = 1'b1;
      tos_ptr_n = tos_ptr + ptr_one_lp;
      count_n   = full ? count : count + cnt_one_lp;
    end else if (push_i && pop_i) begin
      // Return then call: replace the top entry in place.
      mem_we    = 1'b1;
      mem_waddr = top_idx;
    end else if (pop_i && !empty) begin
      tos_ptr_n = top_idx;
      count_n   = count - cnt_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tos_ptr <= '0;
      count   <= '0;
    end else begin
      tos_ptr <= tos_ptr_n;
      count   <= count_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i)
      mem[mem_waddr] <= w_data_i;
  end

`ifdef BP_FE_RAS_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic overflow_ev, underflow_ev;
  assign overflow_ev  = ~restore_i & push_i & ~pop_i & full;
  assign underflow_ev = ~restore_i & pop_i & ~push_i & empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_cnt_o  <= '0;
      underflow_cnt_o <= '0;
    end else begin
      if (overflow_ev)  overflow_cnt_o  <= sat_inc16(overflow_cnt_o);
      if (underflow_ev) underflow_cnt_o <= sat_inc16(underflow_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_ras.sv
// Directed self-checking bench for bp_fe_ras (els_p=8, width_p=39).
module tb_bp_fe_ras;

  localparam int W = 39;

  logic         clk_i = 1'b0;
  logic         reset_i, push_i, pop_i, restore_i;
  logic [W-1:0] w_data_i;
  logic [W-1:0] r_data_o;
  logic         r_v_o, full_o;
  logic [3:0]   count_o, restore_count_i;
  logic [2:0]   ckpt_ptr_o, restore_ptr_i;
`ifdef BP_FE_RAS_STATS_EN
  logic [15:0]  overflow_cnt_o, underflow_cnt_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  bp_fe_ras #(.width_p(W), .els_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(push_i), .w_data_i(w_data_i),
    .pop_i(pop_i), .r_data_o(r_data_o), .r_v_o(r_v_o), .full_o(full_o),
    .count_o(count_o), .ckpt_ptr_o(ckpt_ptr_o), .restore_i(restore_i),
    .restore_ptr_i(restore_ptr_i),
`ifdef BP_FE_RAS_STATS_EN
    .restore_count_i(restore_count_i),
    .overflow_cnt_o(overflow_cnt_o), .underflow_cnt_o(underflow_cnt_o)
`else
    .restore_count_i(restore_count_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock with the given controls, then sample 1 unit after the edge.
  task automatic cyc(input logic rst, input logic psh, input logic pp, input logic [W-1:0] d);
    reset_i = rst; push_i = psh; pop_i = pp; w_data_i = d;
    @(posedge clk_i); #1;
    reset_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; w_data_i = '0;
  endtask

  task automatic rs(input logic [2:0] p, input logic [3:0] c, input logic pp);
    restore_i = 1'b1; restore_ptr_i = p; restore_count_i = c; pop_i = pp;
    @(posedge clk_i); #1;
    restore_i = 1'b0; restore_ptr_i = '0; restore_count_i = '0; pop_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; w_data_i = '0;
    restore_i = 1'b0; restore_ptr_i = '0; restore_count_i = '0;
    #2;
    cyc(1, 0, 0, 0);
    chk("rst_rv",    r_v_o,      0);
    chk("rst_rdata", r_data_o,   0);
    chk("rst_full",  full_o,     0);
    chk("rst_count", count_o,    0);
    chk("rst_ptr",   ckpt_ptr_o, 0);

    // Basic push/pop
    cyc(0, 1, 0, 'h100);
    chk("p1_rdata", r_data_o, 'h100);
    cyc(0, 1, 0, 'h200);
    cyc(0, 1, 0, 'h300);
    chk("p3_count", count_o, 3);
    chk("p3_rdata", r_data_o, 'h300);
    cyc(0, 0, 1, 0); chk("pop1_rdata", r_data_o, 'h200);
    cyc(0, 0, 1, 0); chk("pop2_rdata", r_data_o, 'h100);
    cyc(0, 0, 1, 0);
    chk("pop3_rv", r_v_o, 0);
    chk("pop3_rdata", r_data_o, 0);

    // Overflow then drain past empty
    for (int i = 1; i <= 9; i++) cyc(0, 1, 0, W'(i));
    chk("ovf_full",  full_o,   1);
    chk("ovf_count", count_o,  8);
    chk("ovf_rdata", r_data_o, 9);
`ifdef BP_FE_RAS_STATS_EN
    chk("ovf_cnt", overflow_cnt_o, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_rdata%0d", i), r_data_o, 64'(9 - i));
      chk($sformatf("drain_rv%0d", i), r_v_o, 1);
      cyc(0, 0, 1, 0);
    end
    chk("drain_empty_rv", r_v_o, 0);
    cyc(0, 0, 1, 0);
    chk("udf_rv",    r_v_o,   0);
    chk("udf_count", count_o, 0);
`ifdef BP_FE_RAS_STATS_EN
    chk("udf_cnt", underflow_cnt_o, 1);
    chk("ovf_cnt_hold", overflow_cnt_o, 1);
`endif

    // Simultaneous push+pop
    cyc(0, 1, 0, 'hA);
    cyc(0, 1, 0, 'hB);
    cyc(0, 1, 1, 'hC);
    chk("pp_count", count_o, 2);
    chk("pp_rdata", r_data_o, 'hC);
    cyc(0, 0, 1, 0);
    chk("pp_pop_rdata", r_data_o, 'hA);
    cyc(0, 0, 1, 0);
    chk("pp_empty", r_v_o, 0);
    cyc(0, 1, 1, 'hD);
    chk("ppe_count", count_o, 1);
    chk("ppe_rdata", r_data_o, 'hD);

    // Checkpoint / restore
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 'h10);
    cyc(0, 1, 0, 'h20);
    chk("ck_ptr",   ckpt_ptr_o, 2);
    chk("ck_count", count_o,    2);
    cyc(0, 1, 0, 'h30);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("ck_drained", count_o, 0);
    rs(3'd2, 4'd2, 1'b1);
    chk("rs_rdata", r_data_o,   'h20);
    chk("rs_count", count_o,    2);
    chk("rs_ptr",   ckpt_ptr_o, 2);
`ifdef BP_FE_RAS_STATS_EN
    chk("rs_udf_cnt", underflow_cnt_o, 0);
`endif

    // Restore count clamp
    rs(3'd0, 4'd15, 1'b0);
    chk("clamp_count", count_o, 8);
    chk("clamp_full",  full_o,  1);

    // Reset wins over push
    cyc(1, 1, 0, 'h77);
    chk("rp_count", count_o,    0);
    chk("rp_rv",    r_v_o,      0);
    chk("rp_ptr",   ckpt_ptr_o, 0);
    cyc(0, 1, 0, 'h55);
    chk("rp_push_rdata", r_data_o, 'h55);
    chk("rp_push_count", count_o,  1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
